// File: rtl/data_mem_unit.sv
// MEM-stage data memory responder: stalls the pipeline for a fixed access latency,
// performs big-endian word/byte loads and stores, and flags illegal requests.
module data_mem_unit #(
  parameter int unsigned Depth   = 256,
  parameter int unsigned Latency = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        store_offset_i,
  input  logic        load_byte_i,
  input  logic [15:0] address_i,
  input  logic [15:0] write_data_i,
  output logic [15:0] read_data_o,
  output logic        stall_o,
  output logic        mem_fault_o
);

  localparam int unsigned IdxW      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW      = (Latency > 2) ? $clog2(Latency - 1) : 1;
  localparam logic [16:0] ByteLimit = 17'(2 * Depth);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_fault_q, mem_fault_d;
  logic [15:0]     read_data_q;

  // Request captured on acceptance so WAIT never re-samples the pipeline inputs.
  logic            req_write_q;
  logic            req_byte_q;
  logic [IdxW:0]   req_addr_q;
  logic [15:0]     req_wdata_q;

  logic [15:0]     mem_q [Depth];

  logic            req;
  logic            illegal;
  logic            do_access;
  logic            acc_write;
  logic            acc_byte;
  logic [IdxW:0]   acc_addr;
  logic [15:0]     acc_wdata;
  logic [IdxW-1:0] acc_idx;
  logic [15:0]     cur_word;
  logic [7:0]      cur_lane;
  logic [15:0]     wr_word;

  assign req     = mem_read_i | mem_write_i;
  assign illegal = (mem_read_i & mem_write_i)
                 | (~load_byte_i & ~store_offset_i & address_i[0])
                 | ({1'b0, address_i} >= ByteLimit);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_fault_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (illegal) begin
            state_d     = StDone;
            mem_fault_d = 1'b1;
          end else if (Latency == 1) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(Latency - 2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // DONE ignores the still-present request so it cannot re-trigger.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    stall_o   = req & (state_q != StDone);
    do_access = ~rst_i & (((state_q == StIdle) & req & ~illegal & (Latency == 1))
                          | ((state_q == StWait) & (cnt_q == '0)));
  end

  assign mem_fault_o = mem_fault_q;
  assign read_data_o = read_data_q;

  // Single-cycle access from IDLE uses live inputs; otherwise the captured request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write = mem_write_i;
      acc_byte  = mem_write_i ? store_offset_i : load_byte_i;
      acc_addr  = address_i[IdxW:0];
      acc_wdata = write_data_i;
    end else begin
      acc_write = req_write_q;
      acc_byte  = req_byte_q;
      acc_addr  = req_addr_q;
      acc_wdata = req_wdata_q;
    end
  end

  assign acc_idx  = acc_addr[IdxW:1];
  assign cur_word = mem_q[acc_idx];
  assign cur_lane = acc_addr[0] ? cur_word[7:0] : cur_word[15:8];

  // Big-endian lanes: even byte address is the high half of the word.
  always_comb begin
    if (!acc_byte) begin
      wr_word = acc_wdata;
    end else if (acc_addr[0]) begin
      wr_word = {cur_word[15:8], acc_wdata[7:0]};
    end else begin
      wr_word = {acc_wdata[7:0], cur_word[7:0]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_write_q <= 1'b0;
      req_byte_q  <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if ((state_q == StIdle) && req) begin
      req_write_q <= mem_write_i;
      req_byte_q  <= mem_write_i ? store_offset_i : load_byte_i;
      req_addr_q  <= address_i[IdxW:0];
      req_wdata_q <= write_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_data_q <= 16'h0000;
    end else if (do_access && !acc_write) begin
      read_data_q <= acc_byte ? {8'h00, cur_lane} : cur_word;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (do_access && acc_write) begin
      mem_q[acc_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed, table-driven bench for data_mem_unit with hand-written sequences for
// reset-during-WAIT and back-to-back request timing.
module tb_data_mem_unit;

  localparam int unsigned Depth   = 256;
  localparam int unsigned Latency = 2;
  localparam int unsigned NumVec  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, store_offset, load_byte;
  logic [15:0] address, write_data;
  logic [15:0] read_data;
  logic        stall, mem_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_unit #(
    .Depth   (Depth),
    .Latency (Latency)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .store_offset_i (store_offset),
    .load_byte_i    (load_byte),
    .address_i      (address),
    .write_data_i   (write_data),
    .read_data_o    (read_data),
    .stall_o        (stall),
    .mem_fault_o    (mem_fault)
  );

  typedef struct {
    logic        rd, wr, so, lb;
    logic [15:0] addr, wd;
    int          exp_stall;
    logic        exp_fault;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic rd, wr, so, lb, input logic [15:0] a, w,
                              input logic fault, input logic [15:0] r);
    vec_t v;
    v.rd = rd; v.wr = wr; v.so = so; v.lb = lb; v.addr = a; v.wd = w;
    v.exp_fault = fault;
    v.exp_stall = fault ? 1 : int'(Latency);
    v.exp_rdata = r;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; store_offset = 1'b0; load_byte = 1'b0;
    address = 16'h0000; write_data = 16'h0000;
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 after DONE.
  task automatic run_req(input vec_t v, output int n_stall, output logic early_fault,
                         output logic done_fault, output logic [15:0] done_rdata,
                         output logic timeout);
    mem_read = v.rd; mem_write = v.wr; store_offset = v.so; load_byte = v.lb;
    address = v.addr; write_data = v.wd;
    n_stall = 0; early_fault = 1'b0; done_fault = 1'b0; done_rdata = 16'h0000;
    timeout = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (stall) begin
        n_stall++;
        if (mem_fault) early_fault = 1'b1;
        @(posedge clk); #1;
      end else begin
        done_fault = mem_fault;
        done_rdata = read_data;
        timeout    = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int          n_stall;
    logic        early_fault, done_fault, timeout;
    logic [15:0] done_rdata;
    run_req(v, n_stall, early_fault, done_fault, done_rdata, timeout);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_stall_cycles"}, 32'(n_stall), 32'(v.exp_stall));
    check({tag, "_fault_during_stall"}, 32'(early_fault), 32'd0);
    check({tag, "_fault_in_done"}, 32'(done_fault), 32'(v.exp_fault));
    check({tag, "_read_data"}, 32'(done_rdata), 32'(v.exp_rdata));
    @(negedge clk);
    check({tag, "_fault_pulse_end"}, 32'(mem_fault), 32'd0);
    @(posedge clk); #1;
  endtask

  logic exp_seq [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                rd    wr    so    lb    addr      wdata     flt   rdata
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h1234, 1'b0, 16'hBEEF);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBE34);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h00BE);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'h0034);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hFFFF, 1'b1, 16'h0034);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0034);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h0034);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h0034);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0013, 16'h0BAD, 1'b1, 16'h0034);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBE34);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hAB77, 1'b0, 16'hBE34);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h7734);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h01FE, 16'hCAFE, 1'b0, 16'h7734);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h01FF, 16'h0000, 1'b0, 16'h00FE);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h01FE, 16'h0000, 1'b0, 16'h00CA);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000, 1'b1, 16'h00CA);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'hAAAA, 1'b0, 16'h00CA);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAAAA);

    // Reset state
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_read_data", 32'(read_data), 32'h0000);
    check("reset_mem_fault", 32'(mem_fault), 32'd0);
    check("reset_stall_no_req", 32'(stall), 32'd0);
    mem_read = 1'b1;
    #1;
    check("reset_stall_follows_req", 32'(stall), 32'd1);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < int'(NumVec); i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while in WAIT of a write: the write must be abandoned.
    mem_write = 1'b1; address = 16'h0020; write_data = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_wait_read_data", 32'(read_data), 32'h0000);
    check("rst_wait_mem_fault", 32'(mem_fault), 32'd0);
    check("rst_wait_stall_idle_req", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_release_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    apply_vec("rst_readback", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAAAA));

    // Back-to-back: write held through DONE, read presented the cycle after DONE.
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0;
    exp_seq[3] = 1'b1; exp_seq[4] = 1'b1; exp_seq[5] = 1'b0;
    mem_write = 1'b1; address = 16'h0040; write_data = 16'h1111;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        mem_write = 1'b0; mem_read = 1'b1; write_data = 16'h0000;
      end
      @(negedge clk);
      check($sformatf("b2b_stall_c%0d", c), 32'(stall), 32'(exp_seq[c]));
      if (c == 2) check("b2b_write_done_rdata", 32'(read_data), 32'hAAAA);
      if (c == 5) begin
        check("b2b_read_rdata", 32'(read_data), 32'h1111);
        check("b2b_read_fault", 32'(mem_fault), 32'd0);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    check("b2b_idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    apply_vec("b2b_readback", mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0041, 16'h0000, 1'b0, 16'h0011));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-memory responder for the MEM stage of the 5-stage pipeline. It answers the MemRead / MemWrite / StoreOffset requests issued by the control unit, holds the pipeline with Stall for a configurable access latency, and returns word or zero-extended byte read data to the MEM/WB register. Illegal requests raise MemFault, which the control unit ORs into Halt.

## Interface
- DEPTH, 256: number of 16-bit words in the array; byte address space is 2*DEPTH.
- LATENCY, 2: stall cycles per legal access; must be at least 1.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemRead  in  1  read request from the MEM stage.
- MemWrite  in  1  write request from the MEM stage.
- StoreOffset  in  1  qualifies MemWrite as a byte store.
- LoadByte  in  1  qualifies MemRead as a load-byte-unsigned.
- Address  in  16  byte address; the ALU result in MEM.
- WriteData  in  16  store data; byte stores use WriteData[7:0].
- ReadData  out  16  word read, or the zero-extended byte for LoadByte.
- Stall  out  1  holds the PC, IF/ID, ID/EX and EX/MEM registers. Combinational.
- MemFault  out  1  one-cycle fault pulse for an illegal request. Registered.

## Operation
- Request: req = MemRead | MemWrite.
- Byte order is big-endian.
  - Address[0]=0 selects word[15:8].
  - Address[0]=1 selects word[7:0].
  - Word index = Address[15:1].
- A request is illegal when any of the following holds:
  - MemRead and MemWrite are both high.
  - It is a word access (not LoadByte and not StoreOffset) with Address[0]=1.
  - Address >= 2*DEPTH.
- States: IDLE, WAIT, DONE. A down-counter cnt is used by WAIT.
- IDLE:
  - If req is low, stay in IDLE.
  - If req is high and the request is legal and LATENCY=1, perform the access at this edge and go to DONE.
  - If req is high and the request is legal and LATENCY>1, load cnt=LATENCY-2 and go to WAIT.
  - If req is high and the request is illegal, go to DONE with a fault pending. The array and ReadData are not touched.
- WAIT:
  - If cnt=0, perform the access at this edge and go to DONE.
  - Otherwise decrement cnt.
  - Inputs are not re-sampled. The pipeline holds them stable while Stall is high.
- DONE:
  - Lasts exactly one cycle. The pipeline advances at the end of this cycle.
  - Request inputs are ignored; the next state is always IDLE. This prevents re-triggering on the still-present request.
- Stall = req & (state != DONE).
- Access rules:
  - Word write: replaces array[idx].
  - Byte write: replaces only the selected lane with WriteData[7:0]. The other lane is preserved.
  - Word read: ReadData <= array[idx].
  - Byte read: ReadData <= {8'h00, selected lane}.
- ReadData holds its value until the next completed read. Writes and faults leave it unchanged.
- MemFault is high only during the DONE cycle of a faulting request.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - ReadData = 16'h0000, MemFault = 0.
  - Stall follows req combinationally, so it is 0 with no request.
- Array contents are not cleared by reset.
- A legal request presented in cycle 0 gives:
  - Stall high for cycles 0 .. LATENCY-1.
  - Array write, or ReadData update, at the edge ending cycle LATENCY-1.
  - DONE in cycle LATENCY, with Stall low.
- A faulting request gives:
  - Stall high in cycle 0 only.
  - MemFault high in cycle 1, with Stall low in cycle 1.
- Back-to-back requests: a new request presented in the cycle after DONE is accepted from IDLE. Minimum spacing is LATENCY+1 cycles.
- Reset in WAIT aborts the access. No array write occurs and the state returns to IDLE immediately. If req is still high after reset release, the access restarts from cycle 0.
- No other stall source is arbitrated here. Hazard stalls are combined outside this block.

## Test plan
- Word path, LATENCY=2:
  - Stimulus: write 16'hBEEF to Address 16'h0010, then read Address 16'h0010.
  - Required: Stall is high for 2 cycles in each access, and ReadData=16'hBEEF in DONE of the read.
- Byte store:
  - Stimulus: with word 16'hBEEF at Address 16'h0010, store byte WriteData=16'h1234 to Address 16'h0011, then word-read Address 16'h0010.
  - Required: ReadData=16'hBE34.
- Load byte unsigned:
  - Stimulus: LoadByte read of Address 16'h0010 holding 16'hBE34.
  - Required: ReadData=16'h00BE, with no sign extension.
- Faults:
  - Stimulus: (a) MemRead and MemWrite both high; (b) word read at Address 16'h0003; (c) access at Address 2*DEPTH.
  - Required: Stall for 1 cycle, MemFault pulse in the next cycle, array and ReadData unchanged.
- Reset mid-access:
  - Stimulus: assert rst during WAIT of a write of 16'h5555 to Address 16'h0020, where that word previously held 16'hAAAA.
  - Required: state returns to IDLE, MemFault=0, ReadData=0, and a later read returns 16'hAAAA.
- Back-to-back:
  - Stimulus: hold the same request through DONE, then present a new read.
  - Required: exactly one access per request, no duplicate write, and the second access starts in the cycle after DONE.
